// File: rtl/ddr_burst_writer_if.sv
// Bundles the FIFO read side, frame control and MIG app/wdf signals of the
// burst writer. The master side is the writer itself; the slave side is the
// environment (FIFO plus MIG).
interface ddr_burst_writer_if #(
    parameter int PIX_WIDTH    = 12,
    parameter int PIX_PER_WORD = 8,
    parameter int ADDR_WIDTH   = 27
);
    logic                        fifo_empty;
    logic                        fifo_rd;
    logic [PIX_WIDTH-1:0]        fifo_data;
    logic                        frame_start;
    logic                        app_rdy;
    logic                        app_en;
    logic [2:0]                  app_cmd;
    logic [ADDR_WIDTH-1:0]       app_addr;
    logic                        app_wdf_rdy;
    logic                        app_wdf_wren;
    logic                        app_wdf_end;
    logic [16*PIX_PER_WORD-1:0]  app_wdf_data;
    logic [2*PIX_PER_WORD-1:0]   app_wdf_mask;
    logic                        frame_done;

    modport master (
        input  fifo_empty, fifo_data, frame_start, app_rdy, app_wdf_rdy,
        output fifo_rd, app_en, app_cmd, app_addr, app_wdf_wren, app_wdf_end,
               app_wdf_data, app_wdf_mask, frame_done
    );

    modport slave (
        output fifo_empty, fifo_data, frame_start, app_rdy, app_wdf_rdy,
        input  fifo_rd, app_en, app_cmd, app_addr, app_wdf_wren, app_wdf_end,
               app_wdf_data, app_wdf_mask, frame_done
    );
endinterface

// File: rtl/ddr_burst_writer.sv
// Drains the camera CDC FIFO, packs PIX_PER_WORD pixels into one MIG app word
// (one 16-bit lane per pixel, first pixel in the LSBs) and issues a single-beat
// write command plus write-data beat per word into a linear frame buffer.
module ddr_burst_writer #(
    parameter int PIX_WIDTH    = 12,
    parameter int PIX_PER_WORD = 8,
    parameter int ADDR_WIDTH   = 27,
    parameter int BASE_ADDR    = 0,
    parameter int ADDR_STEP    = 8,
    parameter int FRAME_WORDS  = 38400
) (
    input  logic               clk,
    input  logic               rst,
    ddr_burst_writer_if.master bus
);
    localparam int CNT_W  = $clog2(PIX_PER_WORD + 1);
    localparam int IDX_W  = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
    localparam int DATA_W = 16 * PIX_PER_WORD;

    localparam logic [CNT_W-1:0]      PPW_C      = CNT_W'(PIX_PER_WORD);
    localparam logic [CNT_W-1:0]      LAST_CAP_C = CNT_W'(PIX_PER_WORD - 1);
    localparam logic [IDX_W-1:0]      LAST_IDX_C = IDX_W'(FRAME_WORDS - 1);
    localparam logic [ADDR_WIDTH-1:0] BASE_C     = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH-1:0] STEP_C     = ADDR_WIDTH'(ADDR_STEP);

    typedef enum logic [0:0] {
        ST_FILL  = 1'b0,
        ST_ISSUE = 1'b1
    } state_t;

    state_t                state_r,   state_nxt_s;
    logic [CNT_W-1:0]      pops_r,    pops_nxt_s;
    logic [CNT_W-1:0]      caps_r,    caps_nxt_s;
    logic                  pend_r,    pend_nxt_s;     // a pop's data arrives this cycle
    logic                  fs_pend_r, fs_pend_nxt_s;  // frame_start seen while issuing
    logic [IDX_W-1:0]      idx_r,     idx_nxt_s;
    logic [ADDR_WIDTH-1:0] addr_r,    addr_nxt_s;
    logic [DATA_W-1:0]     data_r,    data_nxt_s;
    logic                  en_r,      en_nxt_s;
    logic                  wren_r,    wren_nxt_s;
    logic                  done_r,    done_nxt_s;
    logic                  fifo_rd_s;
    logic [15:0]           lane_s;

    // Next-state, counter, lane-packing and handshake logic for FILL/ISSUE.
    always_comb begin
        state_nxt_s   = state_r;
        pops_nxt_s    = pops_r;
        caps_nxt_s    = caps_r;
        pend_nxt_s    = 1'b0;
        fs_pend_nxt_s = fs_pend_r;
        idx_nxt_s     = idx_r;
        addr_nxt_s    = addr_r;
        data_nxt_s    = data_r;
        en_nxt_s      = en_r;
        wren_nxt_s    = wren_r;
        done_nxt_s    = 1'b0;
        fifo_rd_s     = 1'b0;
        lane_s        = {{(16-PIX_WIDTH){1'b0}}, bus.fifo_data};

        case (state_r)
            ST_FILL: begin
                fifo_rd_s = !rst && !bus.fifo_empty && (pops_r < PPW_C);
                if (bus.frame_start) begin
                    // Drop the partial word and any pop still in flight.
                    pops_nxt_s = {CNT_W{1'b0}};
                    caps_nxt_s = {CNT_W{1'b0}};
                    addr_nxt_s = BASE_C;
                    idx_nxt_s  = {IDX_W{1'b0}};
                end else begin
                    pend_nxt_s = fifo_rd_s;
                    if (fifo_rd_s) begin
                        pops_nxt_s = pops_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    end else begin
                        pops_nxt_s = pops_r;
                    end
                    if (pend_r) begin
                        for (int k = 0; k < PIX_PER_WORD; k++) begin
                            if (caps_r == CNT_W'(k)) begin
                                data_nxt_s[16*k +: 16] = lane_s;
                            end
                        end
                        if (caps_r == LAST_CAP_C) begin
                            state_nxt_s = ST_ISSUE;
                            pops_nxt_s  = {CNT_W{1'b0}};
                            caps_nxt_s  = {CNT_W{1'b0}};
                            en_nxt_s    = 1'b1;
                            wren_nxt_s  = 1'b1;
                        end else begin
                            caps_nxt_s = caps_r + {{(CNT_W-1){1'b0}}, 1'b1};
                        end
                    end else begin
                        caps_nxt_s = caps_r;
                    end
                end
            end
            ST_ISSUE: begin
                en_nxt_s      = en_r && !bus.app_rdy;
                wren_nxt_s    = wren_r && !bus.app_wdf_rdy;
                fs_pend_nxt_s = fs_pend_r || bus.frame_start;
                if (!en_nxt_s && !wren_nxt_s) begin
                    state_nxt_s   = ST_FILL;
                    fs_pend_nxt_s = 1'b0;
                    if (idx_r == LAST_IDX_C) begin
                        addr_nxt_s = BASE_C;
                        idx_nxt_s  = {IDX_W{1'b0}};
                        done_nxt_s = 1'b1;
                    end else if (fs_pend_r || bus.frame_start) begin
                        addr_nxt_s = BASE_C;
                        idx_nxt_s  = {IDX_W{1'b0}};
                    end else begin
                        addr_nxt_s = addr_r + STEP_C;
                        idx_nxt_s  = idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
                    end
                end else begin
                    state_nxt_s = ST_ISSUE;
                end
            end
            default: begin
                state_nxt_s = ST_FILL;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_FILL;
            pops_r    <= {CNT_W{1'b0}};
            caps_r    <= {CNT_W{1'b0}};
            pend_r    <= 1'b0;
            fs_pend_r <= 1'b0;
            idx_r     <= {IDX_W{1'b0}};
            addr_r    <= BASE_C;
            data_r    <= {DATA_W{1'b0}};
            en_r      <= 1'b0;
            wren_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            pops_r    <= pops_nxt_s;
            caps_r    <= caps_nxt_s;
            pend_r    <= pend_nxt_s;
            fs_pend_r <= fs_pend_nxt_s;
            idx_r     <= idx_nxt_s;
            addr_r    <= addr_nxt_s;
            data_r    <= data_nxt_s;
            en_r      <= en_nxt_s;
            wren_r    <= wren_nxt_s;
            done_r    <= done_nxt_s;
        end
    end

    assign bus.fifo_rd      = fifo_rd_s;
    assign bus.app_en       = en_r;
    assign bus.app_cmd      = 3'b000;
    assign bus.app_addr     = addr_r;
    assign bus.app_wdf_wren = wren_r;
    assign bus.app_wdf_end  = wren_r;
    assign bus.app_wdf_data = data_r;
    assign bus.app_wdf_mask = {(2*PIX_PER_WORD){1'b0}};
    assign bus.frame_done   = done_r;
endmodule

// File: tb/tb_ddr_burst_writer.sv
// Directed bench for ddr_burst_writer: a small FIFO model, MIG ready controls
// and accept/done logs; each scenario task checks its own expectations.
module tb_ddr_burst_writer;
    localparam int PW  = 12;
    localparam int PPW = 8;
    localparam int AW  = 27;
    localparam int FW  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ddr_burst_writer_if #(.PIX_WIDTH(PW), .PIX_PER_WORD(PPW), .ADDR_WIDTH(AW)) bus ();

    ddr_burst_writer #(
        .PIX_WIDTH(PW), .PIX_PER_WORD(PPW), .ADDR_WIDTH(AW),
        .BASE_ADDR(0), .ADDR_STEP(8), .FRAME_WORDS(FW)
    ) dut (.clk(clk), .rst(rst), .bus(bus));

    int pass_n = 0;
    int total_n = 0;

    // FIFO model: data appears the cycle after a pop.
    logic [11:0] mem [0:255];
    int   wr_ptr = 0;
    int   rd_ptr = 0;
    logic gate_empty = 1'b0;
    logic flush = 1'b0;
    int   bad_pop_n = 0;
    int   issue_pop_n = 0;
    assign bus.fifo_empty = (wr_ptr == rd_ptr) || gate_empty;

    // Pops the FIFO model and counts pops that should never happen.
    always @(posedge clk) begin
        if (flush) begin
            rd_ptr <= wr_ptr;
        end else if (bus.fifo_rd) begin
            bus.fifo_data <= mem[rd_ptr[7:0]];
            rd_ptr <= rd_ptr + 1;
        end
        if (bus.fifo_rd && bus.fifo_empty) bad_pop_n <= bad_pop_n + 1;
        if (bus.fifo_rd && (bus.app_en || bus.app_wdf_wren)) issue_pop_n <= issue_pop_n + 1;
    end

    // MIG-side logs of accepted commands, data beats and frame_done pulses.
    int          cyc = 0;
    logic [26:0] cmd_addr [0:63];
    int          cmd_cyc  [0:63];
    int          cmd_n = 0;
    logic [127:0] wd_data [0:63];
    int          wd_n = 0;
    int          done_n = 0;
    int          done_cyc = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.app_en && bus.app_rdy) begin
            cmd_addr[cmd_n[5:0]] <= bus.app_addr;
            cmd_cyc[cmd_n[5:0]]  <= cyc;
            cmd_n <= cmd_n + 1;
        end
        if (bus.app_wdf_wren && bus.app_wdf_rdy) begin
            wd_data[wd_n[5:0]] <= bus.app_wdf_data;
            wd_n <= wd_n + 1;
        end
        if (bus.frame_done) begin
            done_n   <= done_n + 1;
            done_cyc <= cyc;
        end
    end

    function automatic logic [127:0] pack(input logic [11:0] first);
        logic [127:0] r;
        r = 128'd0;
        for (int k = 0; k < PPW; k++) r[16*k +: 16] = {4'h0, first + 12'(k)};
        return r;
    endfunction

    task automatic push(input logic [11:0] v);
        mem[wr_ptr[7:0]] = v;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic push_run(input logic [11:0] first, input int n);
        for (int i = 0; i < n; i++) push(first + 12'(i));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; flush = 1'b1; gate_empty = 1'b0;
        bus.app_rdy = 1'b1; bus.app_wdf_rdy = 1'b1; bus.frame_start = 1'b0;
        repeat (2) @(negedge clk);
        flush = 1'b0; rst = 1'b0;
    endtask

    task automatic wait_words(input int target, input int budget, output bit ok);
        for (int i = 0; i < budget; i++) begin
            if (cmd_n >= target && wd_n >= target) break;
            @(negedge clk);
        end
        ok = (cmd_n >= target && wd_n >= target);
    endtask

    task automatic wait_en(input int budget, output bit ok);
        for (int i = 0; i < budget; i++) begin
            if (bus.app_en) break;
            @(negedge clk);
        end
        ok = bus.app_en;
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.app_rdy = 1'b1; bus.app_wdf_rdy = 1'b1; bus.frame_start = 1'b0;
        flush = 1'b1;
        repeat (3) @(negedge clk);
        flush = 1'b0;
        push(12'h055);
        #1;
        total_n++; if (bus.fifo_rd !== 1'b0) $display("FAIL reset_fifo_rd: got %0b want 0", bus.fifo_rd); else pass_n++;
        total_n++; if (bus.app_en !== 1'b0) $display("FAIL reset_app_en: got %0b want 0", bus.app_en); else pass_n++;
        total_n++; if (bus.app_wdf_wren !== 1'b0 || bus.app_wdf_end !== 1'b0) $display("FAIL reset_wren: got %0b/%0b want 0/0", bus.app_wdf_wren, bus.app_wdf_end); else pass_n++;
        total_n++; if (bus.app_addr !== 27'd0) $display("FAIL reset_addr: got %0h want 0", bus.app_addr); else pass_n++;
        total_n++; if (bus.app_wdf_data !== 128'd0) $display("FAIL reset_data: got %0h want 0", bus.app_wdf_data); else pass_n++;
        total_n++; if (bus.frame_done !== 1'b0) $display("FAIL reset_done: got %0b want 0", bus.frame_done); else pass_n++;
        total_n++; if (bus.app_cmd !== 3'b000 || bus.app_wdf_mask !== 16'h0000) $display("FAIL reset_cmd_mask: got %0h/%0h want 0/0", bus.app_cmd, bus.app_wdf_mask); else pass_n++;
    endtask

    task automatic test_single_word();
        int b; bit ok; logic [11:0] pat;
        do_reset();
        b = cmd_n;
        push_run(12'h001, 8);
        pat = 12'h000;
        for (int i = 0; i < 12; i++) begin
            #1; pat[i] = bus.fifo_rd;
            @(negedge clk);
        end
        total_n++; if (pat !== 12'h0FF) $display("FAIL single_pop_pattern: got %03h want 0ff", pat); else pass_n++;
        wait_words(b + 1, 40, ok);
        total_n++; if (!ok) $display("FAIL single_timeout: got cmds %0d want %0d", cmd_n - b, 1); else pass_n++;
        total_n++; if (cmd_addr[b[5:0]] !== 27'd0) $display("FAIL single_addr: got %0h want 0", cmd_addr[b[5:0]]); else pass_n++;
        total_n++; if (wd_data[b[5:0]] !== 128'h0008_0007_0006_0005_0004_0003_0002_0001) $display("FAIL single_data: got %h want 0008_0007_..._0001", wd_data[b[5:0]]); else pass_n++;
    endtask

    task automatic test_cmd_stall();
        int b; bit ok; int en_c; int wr_c; int pop_c; bit unstable; bit endbad;
        logic [26:0] a0; logic [127:0] d0;
        do_reset();
        b = cmd_n;
        bus.app_rdy = 1'b0;
        push_run(12'h011, 16);
        wait_en(40, ok);
        total_n++; if (!ok) $display("FAIL stall_en_timeout: got app_en %0b want 1", bus.app_en); else pass_n++;
        a0 = bus.app_addr; d0 = bus.app_wdf_data;
        en_c = 0; wr_c = 0; pop_c = 0; unstable = 1'b0; endbad = 1'b0;
        for (int i = 0; i < 7; i++) begin
            if (bus.app_en) en_c++;
            if (bus.app_wdf_wren) wr_c++;
            if (bus.app_wdf_end !== bus.app_wdf_wren) endbad = 1'b1;
            if (i < 6 && bus.fifo_rd) pop_c++;
            if (bus.app_en && (bus.app_addr !== a0 || bus.app_wdf_data !== d0)) unstable = 1'b1;
            if (i == 5) bus.app_rdy = 1'b1;
            @(negedge clk);
        end
        total_n++; if (en_c != 6) $display("FAIL stall_en_cycles: got %0d want 6", en_c); else pass_n++;
        total_n++; if (wr_c != 1) $display("FAIL stall_wren_cycles: got %0d want 1", wr_c); else pass_n++;
        total_n++; if (pop_c != 0) $display("FAIL stall_pops: got %0d want 0", pop_c); else pass_n++;
        total_n++; if (unstable || endbad) $display("FAIL stall_stable: got unstable=%0b endbad=%0b want 0/0", unstable, endbad); else pass_n++;
        total_n++; if (a0 !== 27'd0 || d0 !== pack(12'h011)) $display("FAIL stall_word: got %0h/%h want 0/%h", a0, d0, pack(12'h011)); else pass_n++;
        wait_words(b + 2, 60, ok);
        total_n++; if (!ok || cmd_addr[(b+1)%64] !== 27'd8) $display("FAIL stall_second_addr: got ok=%0b addr=%0h want 8", ok, cmd_addr[(b+1)%64]); else pass_n++;
        total_n++; if (bad_pop_n != 0 || issue_pop_n != 0) $display("FAIL pop_protocol: got bad=%0d issue=%0d want 0/0", bad_pop_n, issue_pop_n); else pass_n++;
    endtask

    task automatic test_frame_wrap();
        int b; int d; bit ok; logic [26:0] exp_a [0:4];
        exp_a[0] = 27'd0; exp_a[1] = 27'd8; exp_a[2] = 27'd16; exp_a[3] = 27'd24; exp_a[4] = 27'd0;
        do_reset();
        b = cmd_n; d = done_n;
        push_run(12'h100, 40);
        wait_words(b + 5, 200, ok);
        total_n++; if (!ok) $display("FAIL wrap_timeout: got cmds %0d want 5", cmd_n - b); else pass_n++;
        for (int i = 0; i < 5; i++) begin
            total_n++; if (cmd_addr[(b+i)%64] !== exp_a[i]) $display("FAIL wrap_addr%0d: got %0d want %0d", i, cmd_addr[(b+i)%64], exp_a[i]); else pass_n++;
        end
        total_n++; if (done_n - d != 1) $display("FAIL wrap_done_count: got %0d want 1", done_n - d); else pass_n++;
        total_n++; if (done_cyc != cmd_cyc[(b+3)%64] + 1) $display("FAIL wrap_done_timing: got cyc %0d want %0d", done_cyc, cmd_cyc[(b+3)%64] + 1); else pass_n++;
        total_n++; if (cmd_cyc[(b+1)%64] - cmd_cyc[b%64] != 10) $display("FAIL wrap_throughput: got %0d want 10", cmd_cyc[(b+1)%64] - cmd_cyc[b%64]); else pass_n++;
        total_n++; if (wd_data[(b+4)%64] !== pack(12'h120)) $display("FAIL wrap_data4: got %h want %h", wd_data[(b+4)%64], pack(12'h120)); else pass_n++;
    endtask

    task automatic test_frame_start_fill();
        int b; int d; bit ok;
        do_reset();
        b = cmd_n; d = done_n;
        push_run(12'h0A1, 8);
        wait_words(b + 1, 40, ok);
        push_run(12'h0B1, 3);
        repeat (8) @(negedge clk);
        bus.frame_start = 1'b1;
        @(negedge clk);
        bus.frame_start = 1'b0;
        push_run(12'h0C1, 8);
        wait_words(b + 2, 60, ok);
        total_n++; if (!ok) $display("FAIL fsfill_timeout: got cmds %0d want 2", cmd_n - b); else pass_n++;
        total_n++; if (cmd_addr[(b+1)%64] !== 27'd0) $display("FAIL fsfill_addr: got %0h want 0", cmd_addr[(b+1)%64]); else pass_n++;
        total_n++; if (wd_data[(b+1)%64] !== pack(12'h0C1)) $display("FAIL fsfill_data: got %h want %h", wd_data[(b+1)%64], pack(12'h0C1)); else pass_n++;
        total_n++; if (done_n != d) $display("FAIL fsfill_no_done: got %0d pulses want 0", done_n - d); else pass_n++;
    endtask

    task automatic test_empty_toggle();
        int b; bit ok;
        do_reset();
        b = cmd_n;
        push_run(12'h2A1, 8);
        for (int i = 0; i < 80; i++) begin
            if (wd_n >= b + 1) break;
            gate_empty = ~gate_empty;
            @(negedge clk);
        end
        gate_empty = 1'b0;
        wait_words(b + 1, 5, ok);
        total_n++; if (!ok) $display("FAIL toggle_timeout: got cmds %0d want 1", cmd_n - b); else pass_n++;
        total_n++; if (wd_data[b%64] !== pack(12'h2A1)) $display("FAIL toggle_data: got %h want %h", wd_data[b%64], pack(12'h2A1)); else pass_n++;
        total_n++; if (bad_pop_n != 0) $display("FAIL toggle_bad_pop: got %0d want 0", bad_pop_n); else pass_n++;
    endtask

    task automatic test_frame_start_issue();
        int b; int d; bit ok;
        do_reset();
        b = cmd_n; d = done_n;
        push_run(12'h301, 8);
        wait_words(b + 1, 40, ok);
        bus.app_rdy = 1'b0;
        push_run(12'h311, 8);
        wait_en(40, ok);
        bus.frame_start = 1'b1;
        @(negedge clk);
        bus.frame_start = 1'b0;
        repeat (2) @(negedge clk);
        bus.app_rdy = 1'b1;
        push_run(12'h321, 8);
        wait_words(b + 3, 80, ok);
        total_n++; if (!ok) $display("FAIL fsissue_timeout: got cmds %0d want 3", cmd_n - b); else pass_n++;
        total_n++; if (cmd_addr[(b+1)%64] !== 27'd8) $display("FAIL fsissue_cur_addr: got %0h want 8", cmd_addr[(b+1)%64]); else pass_n++;
        total_n++; if (cmd_addr[(b+2)%64] !== 27'd0) $display("FAIL fsissue_next_addr: got %0h want 0", cmd_addr[(b+2)%64]); else pass_n++;
        total_n++; if (done_n != d) $display("FAIL fsissue_no_done: got %0d pulses want 0", done_n - d); else pass_n++;
    endtask

    task automatic test_reset_issue();
        int b; bit ok;
        do_reset();
        push_run(12'h401, 8);
        wait_words(cmd_n + 1, 40, ok);
        bus.app_rdy = 1'b0; bus.app_wdf_rdy = 1'b0;
        push_run(12'h411, 8);
        wait_en(40, ok);
        total_n++; if (!ok) $display("FAIL rstissue_en_timeout: got app_en %0b want 1", bus.app_en); else pass_n++;
        rst = 1'b1;
        @(negedge clk);
        total_n++; if (bus.app_en !== 1'b0 || bus.app_wdf_wren !== 1'b0) $display("FAIL rstissue_drop: got en=%0b wren=%0b want 0/0", bus.app_en, bus.app_wdf_wren); else pass_n++;
        total_n++; if (bus.app_addr !== 27'd0 || bus.app_wdf_data !== 128'd0) $display("FAIL rstissue_clear: got addr=%0h data=%h want 0/0", bus.app_addr, bus.app_wdf_data); else pass_n++;
        rst = 1'b0; bus.app_rdy = 1'b1; bus.app_wdf_rdy = 1'b1;
        b = cmd_n;
        push_run(12'h4C1, 8);
        wait_words(b + 1, 40, ok);
        total_n++; if (!ok || cmd_addr[b%64] !== 27'd0) $display("FAIL rstissue_next_addr: got ok=%0b addr=%0h want 0", ok, cmd_addr[b%64]); else pass_n++;
        total_n++; if (wd_data[b%64] !== pack(12'h4C1)) $display("FAIL rstissue_next_data: got %h want %h", wd_data[b%64], pack(12'h4C1)); else pass_n++;
    endtask

    initial begin
        bus.app_rdy = 1'b1;
        bus.app_wdf_rdy = 1'b1;
        bus.frame_start = 1'b0;
        test_reset();
        test_single_word();
        test_cmd_stall();
        test_frame_wrap();
        test_frame_start_fill();
        test_empty_toggle();
        test_frame_start_issue();
        test_reset_issue();
        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end
endmodule
